// File: rtl/instruction_loader.sv
// Loads a program into instruction RAM from a length-prefixed byte stream, packing big-endian 32-bit words.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the last data word.
module instruction_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [31:0]           mem_wd,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_t;

   localparam int          DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

   state_t                state, next_state;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   wc_next;
   logic [31:0]           shift_reg;
   logic [1:0]            byte_idx;
   logic [31:0]           timer;
   logic                  err_q;
   logic                  accept;
   logic                  timing_out;
   logic                  set_error;
   logic [31:0]           len_req;
   logic                  len_bad;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   assign byte_ready = (state == S_LEN) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                       || (state == S_CSUM)
`endif
                       ;
   assign accept     = byte_ready && byte_valid;
   assign timing_out = (TIMEOUT != 0) && byte_ready && !accept && (timer == TIMER_LAST);
   // A length byte of zero stands for a full memory image.
   assign len_req    = (byte_data == 8'd0) ? 32'(DEPTH) : {24'd0, byte_data};
   assign len_bad    = len_req > 32'(DEPTH);
   assign wc_next    = word_count + 1'b1;

   assign mem_we = (state == S_WRITE);
   assign mem_a  = mem_we ? word_count[ADDR_WIDTH-1:0] : '0;
   assign mem_wd = mem_we ? shift_reg : '0;
   assign busy   = (state != S_IDLE) && (state != S_FIN);
   assign done   = (state == S_FIN);
   assign error  = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      set_error  = 1'b0;
      case (state)
         S_IDLE: if (start) next_state = S_LEN;
         S_LEN: begin
            if (accept) begin
               next_state = len_bad ? S_FIN : S_DATA;
               set_error  = len_bad;
            end else if (timing_out) begin
               next_state = S_FIN;
               set_error  = 1'b1;
            end
         end
         S_DATA: begin
            if (accept && byte_idx == 2'd3) begin
               next_state = S_WRITE;
            end else if (timing_out) begin
               next_state = S_FIN;
               set_error  = 1'b1;
            end
         end
         S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
            next_state = (wc_next == len) ? S_CSUM : S_DATA;
`else
            next_state = (wc_next == len) ? S_FIN : S_DATA;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               next_state = S_FIN;
               set_error  = (byte_data != csum);
            end else if (timing_out) begin
               next_state = S_FIN;
               set_error  = 1'b1;
            end
         end
`endif
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Idle timer restarts on every accepted byte; states without byte_ready hold it at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len        <= '0;
         word_count <= '0;
         shift_reg  <= '0;
         byte_idx   <= '0;
         timer      <= '0;
         err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         timer <= (byte_ready && !accept) ? timer + 32'd1 : 32'd0;
         if (state == S_IDLE && start) begin
            err_q      <= 1'b0;
            word_count <= '0;
            shift_reg  <= '0;
            byte_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
         end else if (set_error) begin
            err_q <= 1'b1;
         end
         if (state == S_LEN && accept && !len_bad) len <= len_req[ADDR_WIDTH:0];
         if (state == S_DATA && accept) begin
            shift_reg <= {shift_reg[23:0], byte_data};
            byte_idx  <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ byte_data;
`endif
         end
         if (state == S_WRITE) word_count <= wc_next;
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader (ADDR_WIDTH=6, TIMEOUT=16); checksum steps run only with LOADER_CHECKSUM_EN.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [5:0]  mem_a;
   logic [31:0] mem_wd;
   logic        busy;
   logic        done;
   logic        error;
   logic [6:0]  word_count;

   int checks   = 0;
   int failures = 0;

   logic [5:0]  wr_a[$];
   logic [31:0] wr_d[$];

   instruction_loader #(.ADDR_WIDTH(6), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_a(mem_a), .mem_wd(mem_wd), .busy(busy), .done(done),
      .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_wd);
      end
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one byte and returns at the falling edge after it was accepted.
   task automatic apply_stimulus(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_output("byte_accept_wait", 64'(n < 50), 1);
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic start_session();
      wr_a.delete();
      wr_d.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 600) begin
         @(negedge clk);
         cycles++;
      end
      check_output("done_seen", done, 1);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (2) @(negedge clk);
      check_output("rst_byte_ready", byte_ready, 0);
      check_output("rst_mem_we", mem_we, 0);
      check_output("rst_mem_a", mem_a, 0);
      check_output("rst_mem_wd", mem_wd, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_error", error, 0);
      check_output("rst_word_count", word_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] two-word program");
      start_session();
      apply_stimulus(8'h02);
      apply_stimulus(8'h28); apply_stimulus(8'h02); apply_stimulus(8'h00); apply_stimulus(8'h05);
      byte_valid = 1'b1;
      byte_data  = 8'h28;
      start      = 1'b1;
      check_output("write_ready_low", byte_ready, 0);
      check_output("write_we", mem_we, 1);
      @(negedge clk);
      start = 1'b0;
      apply_stimulus(8'h28); apply_stimulus(8'h03); apply_stimulus(8'h00); apply_stimulus(8'h0c);
      wait_done(cyc);
      check_output("a_writes", wr_a.size(), 2);
      if (wr_a.size() == 2) begin
         check_output("a_addr0", wr_a[0], 0);
         check_output("a_data0", wr_d[0], 32'h28020005);
         check_output("a_addr1", wr_a[1], 1);
         check_output("a_data1", wr_d[1], 32'h2803000c);
      end
      check_output("a_word_count", word_count, 2);
      check_output("a_error", error, 0);
      @(negedge clk);
      check_output("a_done_pulse", done, 0);
      check_output("a_busy_low", busy, 0);

      $display("[TB] full 64-word image");
      start_session();
      apply_stimulus(8'h00);
      for (int i = 0; i < 256; i++) apply_stimulus(8'(i));
      wait_done(cyc);
      check_output("b_writes", wr_a.size(), 64);
      for (int k = 0; k < wr_a.size() && k < 64; k++) begin
         check_output("b_addr", wr_a[k], k);
         check_output("b_data", wr_d[k], {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
      end
      check_output("b_word_count", word_count, 64);
      check_output("b_error", error, 0);
      @(negedge clk);

      $display("[TB] oversize length");
      start_session();
      apply_stimulus(8'h41);
      wait_done(cyc);
      check_output("c_error", error, 1);
      check_output("c_writes", wr_a.size(), 0);
      check_output("c_word_count", word_count, 0);
      @(negedge clk);
      check_output("c_busy_low", busy, 0);
      check_output("c_error_sticky", error, 1);

      $display("[TB] timeout after two data bytes");
      start_session();
      check_output("d_error_cleared", error, 0);
      apply_stimulus(8'h01);
      apply_stimulus(8'haa); apply_stimulus(8'hbb);
      wait_done(cyc);
      check_output("d_timeout_cycles", cyc, 16);
      check_output("d_error", error, 1);
      check_output("d_writes", wr_a.size(), 0);
      @(negedge clk);
      check_output("d_error_sticky", error, 1);

      $display("[TB] reset mid-word");
      start_session();
      check_output("e_error_cleared", error, 0);
      apply_stimulus(8'h01);
      apply_stimulus(8'h11); apply_stimulus(8'h22);
      byte_valid = 1'b1;
      byte_data  = 8'h33;
      rst_n = 1'b0;
      #1;
      check_output("e_busy_async", busy, 0);
      check_output("e_ready_async", byte_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      byte_valid = 1'b0;
      check_output("e_writes", wr_a.size(), 0);
      check_output("e_word_count", word_count, 0);
      check_output("e_busy", busy, 0);

`ifdef LOADER_CHECKSUM_EN
      $display("[TB] checksum good");
      start_session();
      apply_stimulus(8'h01);
      apply_stimulus(8'h12); apply_stimulus(8'h34); apply_stimulus(8'h56); apply_stimulus(8'h78);
      apply_stimulus(8'h08);
      wait_done(cyc);
      check_output("f_writes", wr_a.size(), 1);
      if (wr_d.size() == 1) check_output("f_data", wr_d[0], 32'h12345678);
      check_output("f_error", error, 0);
      @(negedge clk);
      $display("[TB] checksum bad");
      start_session();
      apply_stimulus(8'h01);
      apply_stimulus(8'h12); apply_stimulus(8'h34); apply_stimulus(8'h56); apply_stimulus(8'h78);
      apply_stimulus(8'h09);
      wait_done(cyc);
      check_output("g_writes", wr_a.size(), 1);
      if (wr_d.size() == 1) check_output("g_data", wr_d[0], 32'h12345678);
      check_output("g_error", error, 1);
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=stuck expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives the write port of the instruction RAM one word per write cycle. Sits between the host byte source (UART receiver or bench) and the instruction memory. `busy` holds the CPU in reset while a program is being loaded.

## Interface

Parameters:
- ADDR_WIDTH, 6, word-address width; memory depth = 2^ADDR_WIDTH words.
- TIMEOUT, 1024, max idle cycles between accepted bytes inside a session; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a load session; honoured only in IDLE.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction RAM write enable, one-cycle pulse per word.
- mem_a  output  ADDR_WIDTH  word address of the write.
- mem_wd  output  32  write data.
- busy  output  1  high from the accepted start until the end of the session.
- done  output  1  one-cycle pulse at session end (success or abort).
- error  output  1  sticky; cleared by the next accepted start.
- word_count  output  ADDR_WIDTH+1  number of words written this session.

## Operation

- A byte is accepted on a rising edge with byte_valid && byte_ready.
- States: IDLE, LEN, DATA, WRITE, CSUM (macro only), FIN.
- IDLE: byte_ready=0. When start=1: clear error, word_count, assembly and checksum registers; go to LEN; set busy=1.
- LEN: byte_ready=1. The first byte is N. N=0 means 2^ADDR_WIDTH words. If N>2^ADDR_WIDTH: set error and go to FIN. Otherwise latch N and go to DATA.
- DATA: byte_ready=1. Shift bytes in, first byte to [31:24]. After the 4th byte of a word, go to WRITE.
- WRITE: exactly one cycle.
  - byte_ready=0; mem_we=1; mem_a=word_count[ADDR_WIDTH-1:0]; mem_wd=assembled word.
  - word_count increments at the end of the cycle.
  - If word_count+1 == N: go to CSUM (macro defined) or FIN. Otherwise go to DATA.
- FIN: one cycle. done=1, busy=0, byte_ready=0; then go to IDLE.
- Timeout: a counter runs in LEN, DATA and CSUM and is cleared on every accepted byte and on state entry. When it reaches TIMEOUT: set error, go to FIN, write no partial word.
- start while not in IDLE is ignored.
- Reset at any point:
  - all outputs return to their reset values immediately;
  - any partial word is discarded;
  - RAM contents already written are untouched.

## Timing

- Reset values: byte_ready=0, mem_we=0, mem_a=0, mem_wd=0, busy=0, done=0, error=0, word_count=0.
- All outputs are registered or decoded from the state register. No combinational path from byte_valid to byte_ready.
- busy rises the cycle after start is sampled.
- mem_we rises the cycle after the 4th byte of a word is accepted. mem_a and mem_wd are stable while mem_we=1.
- Peak throughput: 4 bytes then 1 WRITE cycle = 5 cycles per word.
- done follows the last WRITE (or the CSUM byte, or the abort) by one cycle. error is valid while done=1 and holds afterwards.
- Minimum session for N=1 without the macro: LEN + 4 DATA + WRITE + FIN = 7 cycles after start is sampled.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - an XOR accumulator runs over all 4N data bytes; the length byte is excluded;
  - after the last WRITE, the loader enters CSUM with byte_ready=1 and accepts one checksum byte;
  - on mismatch, error=1; the written words remain in RAM;
  - then go to FIN;
  - the timeout also applies in CSUM.
- Not defined: no CSUM state and no accumulator; FIN follows the last WRITE directly.

## Test plan

- Start, stream 02 28 02 00 05 28 03 00 0c:
  - two mem_we pulses: a=0, wd=0x28020005, then a=1, wd=0x2803000c;
  - then done pulse, word_count=2, error=0.
- Length byte 0x00, 256 data bytes: 64 writes with a=0..63, word_count=64, done, error=0, no address wrap.
- Length byte 0x41 (65): error=1, done pulse, no mem_we, busy low after FIN.
- TIMEOUT=16, N=1, stall after 2 data bytes: error=1 and done exactly 16 cycles after the 2nd byte, no mem_we.
- Hold byte_valid=1 through WRITE:
  - byte_ready=0 and no byte is consumed in that cycle;
  - start pulsed mid-session is ignored;
  - rst_n low mid-word: busy=0 immediately and no write follows.
- With LOADER_CHECKSUM_EN, N=1:
  - stream 01 12 34 56 78 08: write of 0x12345678, error=0;
  - same stream ending 09: write still occurs, error=1.
